multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath: drives every datapath control strobe from a Moore FSM
//  (FETCH/DECODE/EXEC/MEM/WB), so instruction fetch and data access share one memory port.
//  Handles memory wait states via a req/ready handshake, with a watchdog.
//  Counts retired instructions. Traps on illegal opcodes and on memory timeout.
// PARAMETERS
//  TIMEOUT_CYC  64  max consecutive mem_ready=0 cycles in FETCH/MEM before trapping; 0 disables the watchdog
//  CNT_W        32  width of retire_cnt
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  reset       in   1      synchronous, active-high
//  Opcode      in   7      instr[6:0] from instruction register; valid from DECODE onward
//  mem_ready   in   1      memory completes the current access this cycle
//  mem_req     out  1      memory access request, held until mem_ready
//  mem_is_fetch out 1      1 = address is PC (fetch); 0 = address is ALU result (data)
//  ir_write    out  1      load instruction register
//  pc_write    out  1      load PC from PC_Next using PcSrc
//  A_Sel       out  1      0 = rs1, 1 = PC
//  B_Sel       out  1      0 = rs2, 1 = imm
//  ALU_Op      out  2      00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
//  PcSrc       out  2      00 pc+4, 01 branch (Branch_Unit resolves), 10 pc+imm, 11 ALU result
//  RegWrite    out  1      register-file write strobe
//  MemWrite    out  1      store strobe; memory commits on the mem_ready cycle
//  MemtoReg    out  2      00 ALU, 01 memory, 10 imm, 11 pc+4
//  ImmSrc      out  3      000 I, 001 S, 010 B, 011 U, 100 J
//  retire      out  1      1-cycle pulse when an instruction completes
//  retire_cnt  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W
//  trap        out  1      sticky; FSM halted
//  trap_cause  out  1      0 = illegal opcode, 1 = memory timeout
//  state_dbg   out  3      current state encoding
// BEHAVIOUR
//  Reset: state=FETCH; wd_cnt=0; retire_cnt=0; trap=0; trap_cause=0. Reset overrides all else, including TRAP.
//  While reset=1, every strobe is 0 (mem_req, ir_write, pc_write, RegWrite, MemWrite, retire).
//  Unlisted outputs are 0 in every state.
//  FETCH: mem_req=1, mem_is_fetch=1.
//    On mem_ready: ir_write=1, go to DECODE.
//    Otherwise stay.
//  DECODE (1 cycle): latch instruction class from Opcode.
//    Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BR, 1101111 JAL,
//    1100111 JALR, 0110111 LUI, 0010111 AUIPC.
//    Legal opcode -> EXEC. Anything else -> TRAP with trap_cause=0.
//    ImmSrc is driven per class from DECODE through WB.
//  EXEC, per class:
//    R:      A=0, B=0, ALU_Op=10
//    I/LOAD/STORE/JALR: A=0, B=1, ALU_Op=11 for I, else 00
//    AUIPC:  A=1, B=1, ALU_Op=00
//    BR:     A=0, B=0, ALU_Op=01, PcSrc=01, pc_write=1, retire=1, go to FETCH
//    LOAD/STORE -> MEM. All other classes -> WB.
//  MEM: mem_req=1, mem_is_fetch=0. ALU controls held as in EXEC. MemWrite=1 for STORE (held with mem_req).
//    On mem_ready: STORE retires and goes to FETCH; LOAD goes to WB.
//  WB (1 cycle): RegWrite=1, pc_write=1, retire=1, then FETCH. Per class:
//    MemtoReg: R/I/AUIPC=00, LOAD=01, LUI=10, JAL/JALR=11
//    PcSrc:    JAL=10, JALR=11 (ALU held), else 00
//  Watchdog: wd_cnt increments each FETCH/MEM cycle with mem_ready=0 and clears on any other cycle.
//    When wd_cnt reaches TIMEOUT_CYC (and TIMEOUT_CYC!=0) -> TRAP with trap_cause=1, no strobes that cycle.
//    A ready arriving on the threshold cycle wins; no trap.
//  TRAP: all strobes 0, mem_req=0, trap=1; exits only via reset.
//  retire_cnt increments on the cycle retire=1.
//  Reset mid-access drops mem_req the same cycle; an uncommitted store is abandoned.
// STRUCTURE
//  rv32_ctrl_pkg: opcode constants, state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7), class enum,
//    ALU_Op/PcSrc/MemtoReg/ImmSrc encodings.
//  Sub-module ctrl_decode: combinational Opcode -> {class, legal}.
//  Top level: FSM register, class register, output decode, watchdog, retire counter.
// TESTING
//  1. ADD, ready every cycle -> 4 cycles FETCH/DECODE/EXEC/WB; WB: RegWrite=1, MemtoReg=00, PcSrc=00; retire_cnt=1.
//  2. LW, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, MemWrite=0; WB with MemtoReg=01; 8 cycles total.
//  3. SW -> MEM cycle with MemWrite=1 and mem_is_fetch=0; no WB; retire on the ready cycle; RegWrite never 1.
//  4. BEQ, then JAL -> BEQ: pc_write in EXEC with PcSrc=01, ImmSrc=010. JAL: WB with PcSrc=10, MemtoReg=11, ImmSrc=100.
//  5. Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=0, no strobes for 20 cycles. Reset -> FETCH, trap=0.
//  6. TIMEOUT_CYC=4, mem_ready stuck 0 in FETCH -> trap_cause=1 after 4 wait cycles.
//     Repeat with ready on the 4th cycle -> no trap.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// instruction classes and datapath select codes.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BR,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } cls_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_RFN  = 2'b10;
    localparam logic [1:0] ALU_IFN  = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_IMM   = 2'b10;
    localparam logic [1:0] PC_ALU   = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_IMM   = 2'b10;
    localparam logic [1:0] WB_PC4   = 2'b11;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;

    // R-type has no immediate; it falls back to the I encoding.
    function automatic logic [2:0] imm_src_of(cls_t c);
        case (c)
            CLS_STORE:         return IMM_S;
            CLS_BR:            return IMM_B;
            CLS_LUI, CLS_AUIPC: return IMM_U;
            CLS_JAL:           return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; flags anything outside RV32I base opcodes as illegal.
module ctrl_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       legal
);

    always_comb begin
        cls   = CLS_R;
        legal = 1'b1;
        case (opcode)
            OP_R:     cls = CLS_R;
            OP_I:     cls = CLS_I;
            OP_LOAD:  cls = CLS_LOAD;
            OP_STORE: cls = CLS_STORE;
            OP_BR:    cls = CLS_BR;
            OP_JAL:   cls = CLS_JAL;
            OP_JALR:  cls = CLS_JALR;
            OP_LUI:   cls = CLS_LUI;
            OP_AUIPC: cls = CLS_AUIPC;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: state register, latched instruction class, memory
// watchdog and retire counter; strobes are decoded from the registered state.
module multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_is_fetch,
    output logic             ir_write,
    output logic             pc_write,
    output logic             A_Sel,
    output logic             B_Sel,
    output logic [1:0]       ALU_Op,
    output logic [1:0]       PcSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic [2:0]       ImmSrc,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trap,
    output logic             trap_cause,
    output logic [2:0]       state_dbg
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    state_t          state;
    cls_t            cls_q;
    cls_t            dec_cls;
    logic            dec_legal;
    logic [WD_W-1:0] wd_cnt;
    logic            mem_wait;
    logic            timeout_hit;

    ctrl_decode u_decode (
        .opcode (Opcode),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    assign mem_wait    = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    // The cycle that would bring the wait count up to the limit is the trapping cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && mem_wait && (wd_cnt == WD_LAST);
    assign trap        = (state == ST_TRAP);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (state == ST_DECODE)
            cls_q <= dec_cls;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            wd_cnt     <= '0;
            retire_cnt <= '0;
            trap_cause <= 1'b0;
        end else begin
            if (mem_wait && (wd_cnt != '1))
                wd_cnt <= wd_cnt + WD_W'(1);
            else if (!mem_wait)
                wd_cnt <= '0;
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
            case (state)
                ST_FETCH: begin
                    if (mem_ready)
                        state <= ST_DECODE;
                    else if (timeout_hit) begin
                        state      <= ST_TRAP;
                        trap_cause <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec_legal)
                        state <= ST_EXEC;
                    else begin
                        state      <= ST_TRAP;
                        trap_cause <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (cls_q == CLS_BR)
                        state <= ST_FETCH;
                    else if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE))
                        state <= ST_MEM;
                    else
                        state <= ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready)
                        state <= (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                    else if (timeout_hit) begin
                        state      <= ST_TRAP;
                        trap_cause <= 1'b1;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_TRAP;
            endcase
        end
    end

    // Reset forces every strobe low even while the state register still holds its old value.
    always_comb begin
        mem_req      = 1'b0;
        mem_is_fetch = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        A_Sel        = 1'b0;
        B_Sel        = 1'b0;
        ALU_Op       = ALU_ADD;
        PcSrc        = PC_PLUS4;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = WB_ALU;
        ImmSrc       = IMM_I;
        retire       = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_write     = mem_ready;
                end
                ST_DECODE: begin
                    if (dec_legal)
                        ImmSrc = imm_src_of(dec_cls);
                end
                ST_EXEC: begin
                    ImmSrc = imm_src_of(cls_q);
                    case (cls_q)
                        CLS_R:     ALU_Op = ALU_RFN;
                        CLS_I: begin
                            B_Sel  = 1'b1;
                            ALU_Op = ALU_IFN;
                        end
                        CLS_LOAD, CLS_STORE, CLS_JALR: B_Sel = 1'b1;
                        CLS_AUIPC: begin
                            A_Sel = 1'b1;
                            B_Sel = 1'b1;
                        end
                        CLS_BR: begin
                            ALU_Op   = ALU_BR;
                            PcSrc    = PC_BR;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    ImmSrc   = imm_src_of(cls_q);
                    mem_req  = 1'b1;
                    B_Sel    = 1'b1;
                    MemWrite = (cls_q == CLS_STORE);
                    retire   = (cls_q == CLS_STORE) && mem_ready;
                end
                ST_WB: begin
                    ImmSrc   = imm_src_of(cls_q);
                    RegWrite = 1'b1;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    case (cls_q)
                        CLS_LOAD: MemtoReg = WB_MEM;
                        CLS_LUI:  MemtoReg = WB_IMM;
                        CLS_JAL: begin
                            MemtoReg = WB_PC4;
                            PcSrc    = PC_IMM;
                        end
                        CLS_JALR: begin
                            MemtoReg = WB_PC4;
                            PcSrc    = PC_ALU;
                            B_Sel    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver plans each instruction's cycles from the
// instruction rules, queues the expected outputs per cycle, and a monitor compares them.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [6:0] R_ADD = 7'b0110011, I_ADDI = 7'b0010011, LW = 7'b0000011,
                           SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_is_fetch, ir_write, pc_write, A_Sel, B_Sel;
    logic [1:0] ALU_Op, PcSrc, MemtoReg;
    logic       RegWrite, MemWrite, retire, trap, trap_cause;
    logic [2:0] ImmSrc, state_dbg;
    logic [7:0] retire_cnt;

    multicycle_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .ir_write(ir_write),
        .pc_write(pc_write), .A_Sel(A_Sel), .B_Sel(B_Sel), .ALU_Op(ALU_Op),
        .PcSrc(PcSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ImmSrc(ImmSrc), .retire(retire), .retire_cnt(retire_cnt), .trap(trap),
        .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_is_fetch, ir_write, pc_write, a_sel, b_sel;
        logic [1:0] alu_op, pc_src;
        logic       reg_write, mem_write;
        logic [1:0] mem_to_reg;
        logic [2:0] imm_src;
        logic       retire, trap, trap_cause;
        logic [2:0] state;
    } exp_t;

    typedef struct packed {
        exp_t       e;
        logic [7:0] cnt;
    } item_t;

    item_t      sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_cnt = 8'd0;
    logic [6:0] legal_ops [9] = '{R_ADD, I_ADDI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC};

    always @(negedge clk) begin
        item_t it;
        exp_t  got;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            got = {mem_req, mem_is_fetch, ir_write, pc_write, A_Sel, B_Sel, ALU_Op, PcSrc,
                   RegWrite, MemWrite, MemtoReg, ImmSrc, retire, trap, trap_cause, state_dbg};
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL ctrl t=%0t state=%0d got=%h exp=%h", $time, state_dbg, got, it.e);
            end
            checks++;
            if (retire_cnt !== it.cnt) begin
                errors++;
                $display("FAIL retire_cnt t=%0t got=%0d exp=%0d", $time, retire_cnt, it.cnt);
            end
        end
    end

    function automatic logic [6:0] rnd7();
        return 7'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] op);
        case (op)
            SW:         return 3'b001;
            BEQ:        return 3'b010;
            LUI, AUIPC: return 3'b011;
            JAL:        return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic exp_t v_state(logic [2:0] st);
        exp_t e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic exp_t v_fetch(logic rdy);
        exp_t e = v_state(3'd0);
        e.mem_req = 1'b1; e.mem_is_fetch = 1'b1; e.ir_write = rdy;
        return e;
    endfunction

    function automatic exp_t v_decode(logic [6:0] op);
        exp_t e = v_state(3'd1);
        if (is_legal(op)) e.imm_src = imm_of(op);
        return e;
    endfunction

    function automatic exp_t v_exec(logic [6:0] op);
        exp_t e = v_state(3'd2);
        e.imm_src = imm_of(op);
        case (op)
            R_ADD:        e.alu_op = 2'b10;
            I_ADDI:       begin e.b_sel = 1'b1; e.alu_op = 2'b11; end
            LW, SW, JALR: e.b_sel = 1'b1;
            AUIPC:        begin e.a_sel = 1'b1; e.b_sel = 1'b1; end
            BEQ:          begin e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = 1'b1; e.retire = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t v_mem(logic [6:0] op, logic rdy);
        exp_t e = v_state(3'd3);
        e.imm_src = imm_of(op);
        e.mem_req = 1'b1; e.b_sel = 1'b1;
        e.mem_write = (op == SW);
        e.retire = (op == SW) && rdy;
        return e;
    endfunction

    function automatic exp_t v_wb(logic [6:0] op);
        exp_t e = v_state(3'd4);
        e.imm_src = imm_of(op);
        e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        case (op)
            LW:   e.mem_to_reg = 2'b01;
            LUI:  e.mem_to_reg = 2'b10;
            JAL:  begin e.mem_to_reg = 2'b11; e.pc_src = 2'b10; end
            JALR: begin e.mem_to_reg = 2'b11; e.pc_src = 2'b11; e.b_sel = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t v_trap(logic cause);
        exp_t e = v_state(3'd7);
        e.trap = 1'b1; e.trap_cause = cause;
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic rdy, input logic [6:0] op, input exp_t e);
        item_t it;
        reset = rst; mem_ready = rdy; Opcode = op;
        it.e = e; it.cnt = model_cnt;
        sb.push_back(it);
        @(posedge clk); #1;
        if (rst) model_cnt = 8'd0;
        else if (e.retire) model_cnt = model_cnt + 8'd1;
    endtask

    // Trapped: a few halted cycles with random inputs, then a reset cycle out of it.
    task automatic trap_and_reset(input logic cause, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rb(), rnd7(), v_trap(cause));
        cyc(1'b1, rb(), rnd7(), v_trap(cause));
    endtask

    task automatic run_instr(input logic [6:0] op, input int fdly, input int mdly, input int tn);
        for (int i = 0; i < fdly; i++) begin
            cyc(1'b0, 1'b0, rnd7(), v_fetch(1'b0));
            if (i == TO - 1) begin trap_and_reset(1'b1, tn); return; end
        end
        cyc(1'b0, 1'b1, rnd7(), v_fetch(1'b1));
        cyc(1'b0, rb(), op, v_decode(op));
        if (!is_legal(op)) begin trap_and_reset(1'b0, tn); return; end
        cyc(1'b0, rb(), rnd7(), v_exec(op));
        if (op == BEQ) return;
        if (op == LW || op == SW) begin
            for (int i = 0; i < mdly; i++) begin
                cyc(1'b0, 1'b0, rnd7(), v_mem(op, 1'b0));
                if (i == TO - 1) begin trap_and_reset(1'b1, tn); return; end
            end
            cyc(1'b0, 1'b1, rnd7(), v_mem(op, 1'b1));
            if (op == SW) return;
        end
        cyc(1'b0, rb(), rnd7(), v_wb(op));
    endtask

    function automatic int rnd_dly();
        return ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        logic [6:0] op;
        @(posedge clk); #1;
        cyc(1'b1, 1'b1, R_ADD, v_state(3'd0));
        cyc(1'b1, 1'b1, rnd7(), v_state(3'd0));

        run_instr(R_ADD, 0, 0, 2);
        run_instr(LW, 0, 3, 2);
        run_instr(SW, 1, 0, 2);
        run_instr(BEQ, 0, 0, 2);
        run_instr(JAL, 0, 0, 2);
        run_instr(JALR, 2, 0, 2);
        run_instr(LUI, 0, 0, 2);
        run_instr(AUIPC, 0, 0, 2);
        run_instr(I_ADDI, 0, 0, 2);
        run_instr(7'b1111111, 0, 0, 20);
        run_instr(R_ADD, 6, 0, 3);
        run_instr(R_ADD, TO - 1, 0, 2);
        run_instr(LW, 0, TO, 2);
        run_instr(SW, 0, TO - 1, 2);

        // Reset in the middle of a stalled store, then a fresh fetch must not inherit the wait count.
        cyc(1'b0, 1'b1, rnd7(), v_fetch(1'b1));
        cyc(1'b0, 1'b0, SW, v_decode(SW));
        cyc(1'b0, 1'b0, rnd7(), v_exec(SW));
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, rnd7(), v_mem(SW, 1'b0));
        cyc(1'b1, 1'b1, rnd7(), v_state(3'd3));
        run_instr(R_ADD, TO - 1, 0, 2);

        for (int i = 0; i < 260; i++) run_instr(R_ADD, 0, 0, 2);

        for (int i = 0; i < 250; i++) begin
            op = ($urandom_range(0, 9) == 0) ? rnd7() : legal_ops[$urandom_range(0, 8)];
            run_instr(op, rnd_dly(), rnd_dly(), int'($urandom_range(1, 4)));
        end

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
